// File: rtl/fadd_acc_if.sv
// rtl/fadd_acc_if.sv - control, operand stream, external adder and result signals of fadd_acc
interface fadd_acc_if;
    logic        start;
    logic [7:0]  len;
    logic        clear;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic        add_stb;
    logic [31:0] add_res;
    logic        add_ovf;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ovf;
    logic        out_ready;

    // Accumulator side
    modport slave (
        input  start, len, clear, in_valid, in_data, add_res, add_ovf, out_ready,
        output in_ready, add_a, add_b, add_stb, out_valid, out_data, out_ovf
    );

    // Environment side: operand producer, external adder and result consumer
    modport master (
        output start, len, clear, in_valid, in_data, add_res, add_ovf, out_ready,
        input  in_ready, add_a, add_b, add_stb, out_valid, out_data, out_ovf
    );
endinterface

// File: rtl/fadd_acc.sv
// rtl/fadd_acc.sv - sums a counted run of IEEE-754 singles through an external combinational fadd
module fadd_acc (
    input  logic         clk,
    input  logic         rst_n,
    fadd_acc_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, WAIT_IN, ADD, DONE} state_t;

    state_t      state_q, state_d;
    logic [7:0]  rem_q, rem_d;
    logic        first_q, first_d;
    logic [31:0] acc_q, acc_d;
    logic        ovf_q, ovf_d;
    logic [31:0] add_a_q, add_a_d;
    logic [31:0] add_b_q, add_b_d;
    logic [31:0] out_data_q, out_data_d;
    logic        out_ovf_q, out_ovf_d;

    logic [7:0]  rem_dec;
    logic        rem_last;

    // rem saturates at zero; the run ends on the operand that consumes the last count
    assign rem_dec  = (rem_q != 8'd0) ? rem_q - 8'd1 : rem_q;
    assign rem_last = (rem_q == 8'd1);

    // Next-state and datapath updates; clear overrides everything else
    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        first_d    = first_q;
        acc_d      = acc_q;
        ovf_d      = ovf_q;
        add_a_d    = add_a_q;
        add_b_d    = add_b_q;
        out_data_d = out_data_q;
        out_ovf_d  = out_ovf_q;

        if (bus.clear) begin
            state_d = IDLE;
            acc_d   = 32'd0;
            rem_d   = 8'd0;
            ovf_d   = 1'b0;
            first_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        acc_d = 32'd0;
                        ovf_d = 1'b0;
                        if (bus.len != 8'd0) begin
                            rem_d   = bus.len;
                            first_d = 1'b1;
                            state_d = WAIT_IN;
                        end else begin
                            out_data_d = 32'd0;
                            out_ovf_d  = 1'b0;
                            state_d    = DONE;
                        end
                    end
                end
                WAIT_IN: begin
                    if (bus.in_valid) begin
                        if (first_q) begin
                            // First operand seeds the accumulator without an add
                            acc_d   = bus.in_data;
                            first_d = 1'b0;
                            rem_d   = rem_dec;
                            if (rem_last) begin
                                out_data_d = bus.in_data;
                                out_ovf_d  = ovf_q;
                                state_d    = DONE;
                            end
                        end else begin
                            add_a_d = acc_q;
                            add_b_d = bus.in_data;
                            state_d = ADD;
                        end
                    end
                end
                ADD: begin
                    acc_d = bus.add_res;
                    ovf_d = ovf_q | bus.add_ovf;
                    rem_d = rem_dec;
                    if (rem_last) begin
                        out_data_d = bus.add_res;
                        out_ovf_d  = ovf_q | bus.add_ovf;
                        state_d    = DONE;
                    end else begin
                        state_d = WAIT_IN;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rem_q      <= 8'd0;
            first_q    <= 1'b0;
            acc_q      <= 32'd0;
            ovf_q      <= 1'b0;
            add_a_q    <= 32'd0;
            add_b_q    <= 32'd0;
            out_data_q <= 32'd0;
            out_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            first_q    <= first_d;
            acc_q      <= acc_d;
            ovf_q      <= ovf_d;
            add_a_q    <= add_a_d;
            add_b_q    <= add_b_d;
            out_data_q <= out_data_d;
            out_ovf_q  <= out_ovf_d;
        end
    end

    assign bus.in_ready  = (state_q == WAIT_IN);
    assign bus.add_stb   = (state_q == ADD);
    assign bus.out_valid = (state_q == DONE);
    assign bus.add_a     = add_a_q;
    assign bus.add_b     = add_b_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ovf   = out_ovf_q;
endmodule
